// File: rtl/gpio_cmd_decoder.sv
// gpio_cmd_decoder: decodes toggle-framed host GPIO command words into the
// control pulses, image length, pixel words and kernel coefficients used by
// the convolution address FSM, and returns status / result data to the host.
module gpio_cmd_decoder #(
    parameter int NB_GPIO  = 32,
    parameter int NB_IMAGE = 10,
    parameter int NB_DATA  = 8,
    parameter int READ_LAT = 2
) (
    input  logic                  i_CLK,
    input  logic                  i_reset,
    input  logic [NB_GPIO-1:0]    i_gpio_data,
    output logic [NB_GPIO-1:0]    o_gpio_data,
    output logic [NB_IMAGE-1:0]   o_imgLength,
    output logic                  o_fsmReset,
    output logic                  o_valid,
    output logic                  o_SoP,
    output logic [3*NB_DATA-1:0]  o_pixels,
    output logic [9*NB_DATA-1:0]  o_kernel,
    input  logic                  i_changeBlock,
    input  logic                  i_EoP,
    input  logic [3*NB_DATA-1:0]  i_memData
);

    localparam int NB_PIX = 3 * NB_DATA;
    localparam int NB_KER = 9 * NB_DATA;
    localparam int NB_RDC = $clog2(READ_LAT + 2);
    localparam logic [NB_RDC-1:0] LP_RD_LAST = NB_RDC'(READ_LAT);

    localparam logic [2:0] OP_NOP      = 3'd0;
    localparam logic [2:0] OP_SET_LEN  = 3'd1;
    localparam logic [2:0] OP_LOAD_PIX = 3'd2;
    localparam logic [2:0] OP_LOAD_KER = 3'd3;
    localparam logic [2:0] OP_START    = 3'd4;
    localparam logic [2:0] OP_READ_PIX = 3'd5;
    localparam logic [2:0] OP_STATUS   = 3'd6;
    localparam logic [2:0] OP_CLEAR    = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_READY   = 3'd2,
        ST_RUN     = 3'd3,
        ST_READOUT = 3'd4
    } state_t;

    // Input stage registers
    logic [NB_GPIO-1:0] r_gpio;
    logic               r_tog_prev;
    logic               r_cmd_vld;
    logic [2:0]         r_op;
    logic               r_tog;
    logic [27:0]        r_pay;
    logic               r_cb_q, r_cb_qq, r_cb_rise;
    logic               r_eop_q, r_eop_qq, r_eop_rise;

    // Decoder state
    state_t              r_state;
    logic [NB_IMAGE-1:0] r_len;
    logic [NB_IMAGE-1:0] r_cnt;
    logic                r_err;
    logic                r_eop_seen;
    logic [NB_KER-1:0]   r_kernel;
    logic [NB_PIX-1:0]   r_pixels;
    logic [NB_GPIO-1:0]  r_gpio_out;
    logic                r_fsm_rst;
    logic                r_valid;
    logic                r_sop;
    logic                r_busy;
    logic [NB_RDC-1:0]   r_rd_cnt;
    logic                r_rd_tog;

    // Next-state values
    state_t              w_state_nx;
    logic [NB_IMAGE-1:0] w_len_nx;
    logic [NB_IMAGE-1:0] w_cnt_nx;
    logic                w_err_nx;
    logic                w_eop_nx;
    logic [NB_KER-1:0]   w_kernel_nx;
    logic [NB_PIX-1:0]   w_pixels_nx;
    logic [NB_GPIO-1:0]  w_gpio_nx;
    logic                w_fsm_rst_nx;
    logic                w_valid_nx;
    logic                w_sop_nx;
    logic                w_busy_nx;
    logic [NB_RDC-1:0]   w_rd_cnt_nx;
    logic                w_rd_tog_nx;
    logic                w_illegal;
    logic                w_len_ok;
    logic [NB_GPIO-1:0]  w_status;

    assign w_len_ok = (r_pay[NB_IMAGE-1:0] >= NB_IMAGE'(8));
    assign w_status = {r_tog, 3'(r_state), r_err, r_eop_seen, r_cnt,
                       {(NB_GPIO-6-NB_IMAGE){1'b0}}};

    // Capture the host word and FSM flags; flag a new command on a toggle change
    // and flag rising edges of the FSM level flags, all aligned to the same stage.
    always_ff @(posedge i_CLK or posedge i_reset) begin
        if (i_reset) begin
            r_gpio     <= '0;
            r_tog_prev <= 1'b0;
            r_cmd_vld  <= 1'b0;
            r_op       <= 3'd0;
            r_tog      <= 1'b0;
            r_pay      <= 28'd0;
            r_cb_q     <= 1'b0;
            r_cb_qq    <= 1'b0;
            r_cb_rise  <= 1'b0;
            r_eop_q    <= 1'b0;
            r_eop_qq   <= 1'b0;
            r_eop_rise <= 1'b0;
        end else begin
            r_gpio     <= i_gpio_data;
            r_tog_prev <= r_gpio[28];
            r_cmd_vld  <= r_gpio[28] ^ r_tog_prev;
            r_op       <= r_gpio[31:29];
            r_tog      <= r_gpio[28];
            r_pay      <= r_gpio[27:0];
            r_cb_q     <= i_changeBlock;
            r_cb_qq    <= r_cb_q;
            r_cb_rise  <= r_cb_q & ~r_cb_qq;
            r_eop_q    <= i_EoP;
            r_eop_qq   <= r_eop_q;
            r_eop_rise <= r_eop_q & ~r_eop_qq;
        end
    end

    // Decoder state register, including the registered outputs.
    always_ff @(posedge i_CLK or posedge i_reset) begin
        if (i_reset) begin
            r_state    <= ST_IDLE;
            r_len      <= '0;
            r_cnt      <= '0;
            r_err      <= 1'b0;
            r_eop_seen <= 1'b0;
            r_kernel   <= '0;
            r_pixels   <= '0;
            r_gpio_out <= '0;
            r_fsm_rst  <= 1'b0;
            r_valid    <= 1'b0;
            r_sop      <= 1'b0;
            r_busy     <= 1'b0;
            r_rd_cnt   <= '0;
            r_rd_tog   <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_len      <= w_len_nx;
            r_cnt      <= w_cnt_nx;
            r_err      <= w_err_nx;
            r_eop_seen <= w_eop_nx;
            r_kernel   <= w_kernel_nx;
            r_pixels   <= w_pixels_nx;
            r_gpio_out <= w_gpio_nx;
            r_fsm_rst  <= w_fsm_rst_nx;
            r_valid    <= w_valid_nx;
            r_sop      <= w_sop_nx;
            r_busy     <= w_busy_nx;
            r_rd_cnt   <= w_rd_cnt_nx;
            r_rd_tog   <= w_rd_tog_nx;
        end
    end

    // Next state: FSM flag edges first, then read wait, then the command judged
    // against the pre-transition state; CLEAR is applied last so it wins.
    always_comb begin
        w_state_nx   = r_state;
        w_len_nx     = r_len;
        w_cnt_nx     = r_cnt;
        w_err_nx     = r_err;
        w_eop_nx     = r_eop_seen;
        w_kernel_nx  = r_kernel;
        w_pixels_nx  = r_pixels;
        w_gpio_nx    = r_gpio_out;
        w_fsm_rst_nx = 1'b0;
        w_valid_nx   = 1'b0;
        w_sop_nx     = 1'b0;
        w_busy_nx    = r_busy;
        w_rd_cnt_nx  = r_rd_cnt;
        w_rd_tog_nx  = r_rd_tog;
        w_illegal    = 1'b0;

        case (r_state)
            ST_LOAD: begin
                if (r_cb_rise) w_state_nx = ST_READY;
                else           w_state_nx = r_state;
            end
            ST_RUN: begin
                if (r_eop_rise) begin
                    w_state_nx = ST_READOUT;
                    w_eop_nx   = 1'b1;
                end else begin
                    w_state_nx = r_state;
                end
            end
            ST_READOUT: begin
                if (r_cb_rise) begin
                    w_state_nx = ST_LOAD;
                    w_cnt_nx   = '0;
                end else begin
                    w_state_nx = r_state;
                end
            end
            default: w_state_nx = r_state;
        endcase

        // Pending read: memory data is valid READ_LAT cycles after the strobe.
        if (r_busy) begin
            if (r_rd_cnt == LP_RD_LAST) begin
                w_gpio_nx = {r_rd_tog, {(NB_GPIO-1-NB_PIX){1'b0}}, i_memData};
                w_busy_nx = 1'b0;
            end else begin
                w_rd_cnt_nx = r_rd_cnt + NB_RDC'(1);
            end
        end else begin
            w_rd_cnt_nx = r_rd_cnt;
        end

        if (r_cmd_vld && r_busy) begin
            // Toggle arriving during a read wait is dropped and flagged.
            w_err_nx = 1'b1;
        end else if (r_cmd_vld) begin
            w_gpio_nx[NB_GPIO-1] = r_tog;
            case (r_op)
                OP_NOP: w_illegal = 1'b0;
                OP_SET_LEN: begin
                    if ((r_state == ST_IDLE || r_state == ST_LOAD) && w_len_ok) begin
                        w_len_nx     = r_pay[NB_IMAGE-1:0];
                        w_fsm_rst_nx = 1'b1;
                        w_state_nx   = ST_LOAD;
                        w_cnt_nx     = '0;
                    end else begin
                        w_illegal = 1'b1;
                    end
                end
                OP_LOAD_PIX: begin
                    if (r_state == ST_LOAD) begin
                        w_pixels_nx = r_pay[NB_PIX-1:0];
                        w_valid_nx  = 1'b1;
                        w_cnt_nx    = r_cnt + NB_IMAGE'(1);
                    end else begin
                        w_illegal = 1'b1;
                    end
                end
                OP_LOAD_KER: begin
                    if (r_state != ST_RUN && r_pay[27:24] <= 4'd8) begin
                        for (int k = 0; k < 9; k++) begin
                            if (r_pay[27:24] == 4'(k))
                                w_kernel_nx[k*NB_DATA +: NB_DATA] = r_pay[NB_DATA-1:0];
                            else
                                w_kernel_nx[k*NB_DATA +: NB_DATA] = r_kernel[k*NB_DATA +: NB_DATA];
                        end
                    end else begin
                        w_illegal = 1'b1;
                    end
                end
                OP_START: begin
                    if (r_state == ST_READY) begin
                        w_sop_nx   = 1'b1;
                        w_state_nx = ST_RUN;
                    end else begin
                        w_illegal = 1'b1;
                    end
                end
                OP_READ_PIX: begin
                    if (r_state == ST_READOUT) begin
                        // Ack is deferred until the memory data is captured.
                        w_gpio_nx[NB_GPIO-1] = r_gpio_out[NB_GPIO-1];
                        w_valid_nx  = 1'b1;
                        w_busy_nx   = 1'b1;
                        w_rd_cnt_nx = '0;
                        w_rd_tog_nx = r_tog;
                    end else begin
                        w_illegal = 1'b1;
                    end
                end
                OP_STATUS: begin
                    w_gpio_nx = w_status;
                    w_err_nx  = 1'b0;
                end
                OP_CLEAR: begin
                    w_state_nx   = ST_IDLE;
                    w_len_nx     = '0;
                    w_cnt_nx     = '0;
                    w_err_nx     = 1'b0;
                    w_eop_nx     = 1'b0;
                    w_fsm_rst_nx = 1'b1;
                end
                default: w_illegal = 1'b1;
            endcase
            if (w_illegal) w_err_nx = 1'b1;
            else           w_err_nx = w_err_nx;
        end else begin
            w_err_nx = w_err_nx;
        end
    end

    assign o_gpio_data = r_gpio_out;
    assign o_imgLength = r_len;
    assign o_fsmReset  = r_fsm_rst;
    assign o_valid     = r_valid;
    assign o_SoP       = r_sop;
    assign o_pixels    = r_pixels;
    assign o_kernel    = r_kernel;

endmodule
